complex_addsub_pipe: RTL and testbench
======================================

COMPLEX_ADDSUB_PIPE -- requirements
Module: complex_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 32: two's-complement width of each real/imaginary operand and result, legal range 8..32.
REQ-002 Parameter CNT_W, default 16: width of the saturation event counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a_real, a_im, b_real, b_im  input  WIDTH each  signed operands.
REQ-008 mode  input  1  0 = c = a+b, 1 = c = a-b; sampled with operands.
REQ-009 scale  input  1  1 = halve result (butterfly scaling); sampled with operands.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 c_real, c_im  output  WIDTH each  signed results.
REQ-013 ovf  output  1  result of this transaction saturated in real or imaginary lane.
REQ-014 sat_count  output  CNT_W  number of saturated transactions since reset/clear.
REQ-015 sat_clear  input  1  synchronous clear of sat_count.

Function
REQ-016 Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
REQ-017 Pipeline has two register stages; an accepted set appears on the outputs exactly 2 cycles later if no stall occurs.
REQ-018 Stage 2 loads when stage 2 is empty or out_ready=1; stage 1 loads when stage 1 is empty or stage 1 moves into stage 2.
REQ-019 in_ready = !s1_valid || (!s2_valid || out_ready); combinational, no path from in_valid.
REQ-020 Sustained throughput: one transaction per cycle while out_ready=1.
REQ-021 Stage 1: each lane forms a WIDTH+1-bit exact sum/difference by sign extension; mode and scale travel with data.
REQ-022 Stage 2, scale=1: result = full WIDTH+1 value arithmetically shifted right by 1 (floor); never overflows, ovf lane bit 0.
REQ-023 Stage 2, scale=0: if the WIDTH+1 value exceeds the WIDTH range, saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1) and set the lane overflow bit.
REQ-024 ovf = real overflow OR imaginary overflow, registered with the result.
REQ-025 Outputs c_real, c_im, ovf hold stable while out_valid=1 and out_ready=0.
REQ-026 sat_count increments by 1 on each output transfer with ovf=1; saturates at all-ones and does not wrap.
REQ-027 sat_clear=1 forces sat_count to 0 next cycle and takes priority over a simultaneous increment.
REQ-028 Data in empty stages is don't-care internally but outputs show the last transferred result.

Reset
REQ-029 rst_n=0 asynchronously clears s1_valid, s2_valid, out_valid, ovf, c_real, c_im and sat_count to 0.
REQ-030 Reset mid-transaction discards all in-flight data; no result is emitted for it after reset release.
REQ-031 in_ready is 1 in the first cycle after reset release.

Verification (WIDTH=16)
REQ-032 Single add: a=(1000,-200), b=(24,50), mode=0, scale=0, out_ready=1 -> 2 cycles later out_valid=1, c=(1024,-150), ovf=0.
REQ-033 Subtract with saturation: a=(32767,-32768), b=(-1,1), mode=1, scale=0 -> c=(32767,-32768), ovf=1, sat_count 0->1.
REQ-034 Scaled butterfly: a=(32767,-3), b=(32767,0), mode=0, scale=1 -> c=(32767,-2), ovf=0.
REQ-035 Back-pressure: stream 4 sets with out_ready=0 from cycle 2 -> in_ready falls after 2 accepted, outputs hold first result; raising out_ready drains all 4 in order with no loss or duplication.
REQ-036 Counter limits: with CNT_W=2, four saturating transfers -> sat_count=3; sat_clear with a simultaneous saturating transfer -> sat_count=0.
REQ-037 Reset during stream: assert rst_n=0 with 2 sets in flight -> out_valid=0 immediately, sat_count=0, no stale output after release.

Source files
------------

// File: rtl/complex_addsub_pipe_if.sv
// Handshake and data bus of the complex add/subtract pipeline: operand side, result side,
// and the saturation counter controls.
interface complex_addsub_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_real;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_real;
  logic signed [WIDTH-1:0] b_im;
  logic                    mode;
  logic                    scale;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] c_real;
  logic signed [WIDTH-1:0] c_im;
  logic                    ovf;
  logic [CNT_W-1:0]        sat_count;
  logic                    sat_clear;

  modport master (
    output in_valid, a_real, a_im, b_real, b_im, mode, scale, out_ready, sat_clear,
    input  in_ready, out_valid, c_real, c_im, ovf, sat_count
  );

  modport slave (
    input  in_valid, a_real, a_im, b_real, b_im, mode, scale, out_ready, sat_clear,
    output in_ready, out_valid, c_real, c_im, ovf, sat_count
  );
endinterface

// File: rtl/complex_addsub_pipe.sv
// Two-stage valid/ready pipeline computing c = a +/- b on complex operands with
// optional halving, per-lane saturation, and a sticky count of saturated results.
module complex_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  complex_addsub_pipe_if.slave bus
);
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 s1_valid;
  logic                 s1_scale;
  logic signed [EW-1:0] s1_re;
  logic signed [EW-1:0] s1_im;

  logic                 s2_load_c;
  logic                 s1_load_c;
  logic signed [EW-1:0] re_sum_c;
  logic signed [EW-1:0] im_sum_c;
  logic [WIDTH-1:0]     re_res_c;
  logic [WIDTH-1:0]     im_res_c;
  logic                 re_ovf_c;
  logic                 im_ovf_c;

  // Reduce an exact WIDTH+1 lane value to WIDTH bits: {overflow, result}.
  function automatic logic [WIDTH:0] lane_finish(input logic signed [EW-1:0] s, input logic sc);
    logic [WIDTH:0] r;
    r = {1'b0, s[WIDTH:1]};
    if (!sc) begin
      if (s[WIDTH] != s[WIDTH-1]) r = {1'b1, (s[WIDTH] ? MIN_V : MAX_V)};
      else                        r = {1'b0, s[WIDTH-1:0]};
    end
    return r;
  endfunction

  // in_ready depends only on pipeline occupancy and out_ready.
  assign s2_load_c    = !bus.out_valid || bus.out_ready;
  assign s1_load_c    = !s1_valid || s2_load_c;
  assign bus.in_ready = s1_load_c;

  always_comb begin
    re_sum_c = bus.mode ? (EW'(bus.a_real) - EW'(bus.b_real)) : (EW'(bus.a_real) + EW'(bus.b_real));
    im_sum_c = bus.mode ? (EW'(bus.a_im)   - EW'(bus.b_im))   : (EW'(bus.a_im)   + EW'(bus.b_im));
  end

  always_comb begin
    {re_ovf_c, re_res_c} = lane_finish(s1_re, s1_scale);
    {im_ovf_c, im_res_c} = lane_finish(s1_im, s1_scale);
  end

  // Stage 1: exact sums; scale travels with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else if (s1_load_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_scale <= bus.scale;
        s1_re    <= re_sum_c;
        s1_im    <= im_sum_c;
      end
    end
  end

  // Stage 2: result register; data only updates on a real load so outputs keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.c_real    <= '0;
      bus.c_im      <= '0;
      bus.ovf       <= 1'b0;
    end else if (s2_load_c) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.c_real <= re_res_c;
        bus.c_im   <= im_res_c;
        bus.ovf    <= re_ovf_c | im_ovf_c;
      end
    end
  end

  // Saturating event counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sat_count <= '0;
    end else if (bus.sat_clear) begin
      bus.sat_count <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.ovf && (bus.sat_count != '1)) begin
      bus.sat_count <= bus.sat_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Directed bench for complex_addsub_pipe (WIDTH=16, CNT_W=2) with a queue-based reference
// model checked every cycle plus literal expectations for the reference vectors.
module tb_complex_addsub_pipe;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    int re;
    int im;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   m_cnt = 0;
  bit   snd_done;
  exp_t q[$];

  complex_addsub_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  complex_addsub_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void lane(input int x, input int y, input bit md, input bit sc,
                               output int r, output bit o);
    int s;
    s = md ? x - y : x + y;
    o = 1'b0;
    if (sc) r = s >>> 1;
    else if (s > 32767) begin r = 32767; o = 1'b1; end
    else if (s < -32768) begin r = -32768; o = 1'b1; end
    else r = s;
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                 input bit md, input bit sc);
    exp_t e;
    bit o1, o2;
    lane(ar, br, md, sc, e.re, o1);
    lane(ai, bi, md, sc, e.im, o2);
    e.ovf = o1 | o2;
    return e;
  endfunction

  // Every-cycle comparison against the reference queue, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_sat_count", longint'(bus.sat_count), 0);
    end else begin
      check("sat_count", longint'(bus.sat_count), m_cnt);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stale_output: out_valid=1 with no result expected (t=%0t)", $time);
        end else begin
          check("c_real", $signed(bus.c_real), q[0].re);
          check("c_im", $signed(bus.c_im), q[0].im);
          check("ovf", longint'(bus.ovf), longint'(q[0].ovf));
        end
      end
      if (bus.sat_clear) m_cnt = 0;
      else if (bus.out_valid && bus.out_ready && q.size() > 0 && q[0].ovf && m_cnt < CNT_MAX)
        m_cnt++;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(int'(bus.a_real), int'(bus.a_im), int'(bus.b_real), int'(bus.b_im),
                          bus.mode, bus.scale));
        n_in++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit md, input bit sc);
    bit acc;
    int t;
    bus.in_valid = 1'b1;
    bus.a_real = 16'(ar);
    bus.a_im   = 16'(ai);
    bus.b_real = 16'(br);
    bus.b_im   = 16'(bi);
    bus.mode   = md;
    bus.scale  = sc;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 100) begin
      cycle();
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
    end
  endtask

  initial begin
    int in0, out0, t;
    bus.in_valid = 1'b0;
    bus.a_real = '0; bus.a_im = '0; bus.b_real = '0; bus.b_im = '0;
    bus.mode = 1'b0; bus.scale = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clear = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", longint'(bus.out_valid), 0);
    check("reset_c_real", longint'(bus.c_real), 0);
    check("reset_ovf", longint'(bus.ovf), 0);
    check("reset_sat_count", longint'(bus.sat_count), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_after_reset", longint'(bus.in_ready), 1);

    // Single add, 2-cycle latency.
    send(1000, -200, 24, 50, 1'b0, 1'b0);
    check("add_lat1_out_valid", longint'(bus.out_valid), 0);
    cycle();
    check("add_out_valid", longint'(bus.out_valid), 1);
    check("add_c_real", $signed(bus.c_real), 1024);
    check("add_c_im", $signed(bus.c_im), -150);
    check("add_ovf", longint'(bus.ovf), 0);
    wait_drain();

    // Subtract saturating both lanes.
    send(32767, -32768, -1, 1, 1'b1, 1'b0);
    cycle();
    check("sub_c_real", $signed(bus.c_real), 32767);
    check("sub_c_im", $signed(bus.c_im), -32768);
    check("sub_ovf", longint'(bus.ovf), 1);
    check("sub_cnt_before", longint'(bus.sat_count), 0);
    cycle();
    check("sub_cnt_after", longint'(bus.sat_count), 1);
    wait_drain();

    // Scaled butterfly: floor halving, no overflow.
    send(32767, -3, 32767, 0, 1'b0, 1'b1);
    cycle();
    check("scl_c_real", $signed(bus.c_real), 32767);
    check("scl_c_im", $signed(bus.c_im), -2);
    check("scl_ovf", longint'(bus.ovf), 0);
    wait_drain();

    // Back-pressure: 4 sets, output stalled.
    bus.out_ready = 1'b0;
    in0 = n_in;
    out0 = n_out;
    snd_done = 1'b0;
    fork
      begin
        send(100, 200, 1, 1, 1'b0, 1'b0);
        send(100, 200, 1, 1, 1'b1, 1'b0);
        send(-5, 7, -5, 7, 1'b0, 1'b1);
        send(30000, -30000, 30000, -30000, 1'b0, 1'b0);
        snd_done = 1'b1;
      end
    join_none
    repeat (4) cycle();
    check("bp_in_ready", longint'(bus.in_ready), 0);
    check("bp_accepted", longint'(n_in - in0), 2);
    check("bp_out_valid", longint'(bus.out_valid), 1);
    check("bp_hold_c_real", $signed(bus.c_real), 101);
    check("bp_hold_c_im", $signed(bus.c_im), 201);
    bus.out_ready = 1'b1;
    t = 0;
    while (!snd_done && t < 300) begin
      cycle();
      t++;
    end
    if (!snd_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_sender_timeout: sender not finished after %0d cycles", t);
    end
    wait_drain();
    check("bp_drained", longint'(n_out - out0), 4);
    check("bp_cnt", longint'(bus.sat_count), 2);

    // Counter saturates at all-ones.
    send(-30000, 0, 30000, 0, 1'b1, 1'b0);
    wait_drain();
    send(0, 20000, 0, -20000, 1'b1, 1'b0);
    wait_drain();
    check("cnt_saturated", longint'(bus.sat_count), 3);

    // Clear wins over a simultaneous saturating transfer.
    send(32767, 0, 1, 0, 1'b0, 1'b0);
    cycle();
    check("clr_out_valid", longint'(bus.out_valid), 1);
    check("clr_ovf", longint'(bus.ovf), 1);
    bus.sat_clear = 1'b1;
    cycle();
    bus.sat_clear = 1'b0;
    check("clr_cnt", longint'(bus.sat_count), 0);
    wait_drain();

    // Reset with two sets in flight.
    send(32767, 0, 1, 0, 1'b0, 1'b0);
    wait_drain();
    check("pre_rst_cnt", longint'(bus.sat_count), 1);
    send(1, 2, 3, 4, 1'b0, 1'b0);
    send(5, 6, 7, 8, 1'b1, 1'b0);
    check("inflight_out_valid", longint'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(bus.out_valid), 0);
    check("mid_rst_sat_count", longint'(bus.sat_count), 0);
    check("mid_rst_c_real", longint'(bus.c_real), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", longint'(bus.in_ready), 1);
    repeat (6) cycle();
    check("post_rst_out_valid", longint'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
